sum_accel_axil: RTL
===================

// Module: sum_accel_axil
// PURPOSE
//  AXI4-Lite slave holding NUM_OPERANDS operand registers plus a sequential adder engine.
//  Software writes operands and sets START; the engine accumulates one operand per cycle.
//  It then posts RESULT/STATUS and pulses IRQ.
//  Next-generation sum IP: generalised operand count/width, adds saturating mode, overflow flag and interrupt.
// PARAMETERS
//  NUM_OPERANDS  4   operand registers, 2..16
//  OP_WIDTH      32  significant operand bits, 8..32; upper WDATA bits are ignored, and reads return zero there
//  ADDR_WIDTH    6   byte-address width; must cover 0x0C+4*NUM_OPERANDS
// PORTS
//  ACLK           in   1   clock, all logic on rising edge
//  ARESET         in   1   synchronous, active-high reset
//  S_AXI_AWADDR   in   ADDR_WIDTH  write address (bits[1:0] ignored)
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1 / S_AXI_AWREADY out 1   write-address handshake
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte enables, honoured per byte
//  S_AXI_WVALID   in   1 / S_AXI_WREADY  out 1   write-data handshake
//  S_AXI_BRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1 / S_AXI_BREADY  in  1   write response
//  S_AXI_ARADDR   in   ADDR_WIDTH  read address
//  S_AXI_ARPROT   in   3   ignored
//  S_AXI_ARVALID  in   1 / S_AXI_ARREADY out 1   read-address handshake
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1 / S_AXI_RREADY  in  1   read data
//  IRQ            out  1   one-cycle pulse when a sum completes
// BEHAVIOUR
//  Reset: all operands, RESULT, CTRL and STATUS = 0; state IDLE; all READY/VALID outputs and IRQ = 0.
//  Map: 0x00 CTRL  [0] START (write-1 self-clears, reads 0), [1] SAT (1 = saturate at 2^OP_WIDTH-1)
//       0x04 STATUS (RO)  [0] BUSY, [1] DONE (sticky, cleared by writing STATUS[1]=1 or by START), [2] OVF
//       0x08 RESULT (RO, OP_WIDTH bits)   0x0C+4k OPERAND[k], k < NUM_OPERANDS
//  Write channel:
//   - AWREADY and WREADY assert together for 1 cycle once AWVALID && WVALID && !BVALID.
//   - Register updates on that cycle; BVALID is asserted the next cycle and held until BREADY.
//  Read channel:
//   - ARREADY is a 1-cycle pulse when ARVALID && !RVALID.
//   - RDATA/RRESP are registered and RVALID rises next cycle, held until RREADY; RDATA is stable while RVALID.
//  Response codes:
//   - SLVERR for an unmapped address (write ignored, RDATA=0) and for any write to an OPERAND or CTRL while BUSY (ignored).
//   - SLVERR for a write to RESULT (ignored).
//  FSM: IDLE -START-> ACCUM -> DONE -> IDLE.
//   - IDLE: START write sets acc=0, idx=0, BUSY=1, DONE=0, OVF=0 and latches SAT.
//   - ACCUM: one operand per cycle, acc += OPERAND[idx] in OP_WIDTH+1 bits.
//     On carry, OVF=1; if SAT, acc saturates to all-ones and stays there; otherwise it wraps mod 2^OP_WIDTH.
//     Exactly NUM_OPERANDS cycles in ACCUM.
//   - DONE: one cycle; RESULT=acc, BUSY=0, DONE=1, IRQ=1.
//   - Latency: START write-handshake cycle to IRQ = NUM_OPERANDS+1 cycles.
//  Simultaneous events:
//   - Reads are allowed any time; a STATUS read races the engine and returns the pre-edge value.
//   - START while BUSY gives SLVERR and is ignored. A write with STATUS[1]=1 in the DONE cycle: DONE is set (set wins).
//  ARESET mid-ACCUM aborts: returns to IDLE and clears all registers; no IRQ is produced.
//   Any outstanding BVALID/RVALID is dropped.
//  Partial WSTRB to CTRL acts only if byte 0 is enabled.
// TESTING
//  1 Reset -> read all registers = 0, OKAY; BVALID, RVALID, IRQ low.
//  2 Ops 1,2,3,4, START -> IRQ 5 cycles after the handshake; RESULT=0xA, STATUS=0x2.
//  3 OP_WIDTH=32, ops 0xFFFFFFFF,2,0,0, SAT=0 -> RESULT=0x1, OVF=1; SAT=1 -> RESULT=0xFFFFFFFF, OVF=1.
//  4 While BUSY: write OPERAND0 and a second START -> both SLVERR; RESULT is unaffected.
//  5 Unmapped 0x3C read/write -> SLVERR, RDATA=0; BREADY/RREADY held low for 10 cycles -> VALID and data stable.
//  6 ARESET asserted 2 cycles into ACCUM -> no IRQ; STATUS=0 and operands=0 after release.

Source files
------------

// File: rtl/sum_accel_axil.sv
// sum_accel_axil: AXI4-Lite slave with NUM_OPERANDS operand registers and a
// sequential adder that sums them one per cycle, then posts RESULT/STATUS and
// pulses IRQ.
//
// Register map (byte addresses):
//   0x00     CTRL    [0] START (write-1, reads 0)  [1] SAT
//   0x04     STATUS  [0] BUSY  [1] DONE (sticky, W1C)  [2] OVF
//   0x08     RESULT  read-only
//   0x0C+4k  OPERAND[k]
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a START write
// S_ACCUM | adding OPERAND[idx] into acc, one operand per cycle
// S_DONE  | single cycle; RESULT/DONE already posted, IRQ high

module sum_accel_axil #(
    parameter int NUM_OPERANDS = 4,
    parameter int OP_WIDTH     = 32,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  IRQ
);

    localparam int IDX_W  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int WORD_W = ADDR_WIDTH - 2;

    localparam logic [WORD_W-1:0] WORD_CTRL     = WORD_W'(0);
    localparam logic [WORD_W-1:0] WORD_STATUS   = WORD_W'(1);
    localparam logic [WORD_W-1:0] WORD_RESULT   = WORD_W'(2);
    localparam logic [WORD_W-1:0] WORD_OP_FIRST = WORD_W'(3);
    localparam logic [WORD_W-1:0] WORD_OP_LAST  = WORD_W'(2 + NUM_OPERANDS);
    localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(NUM_OPERANDS - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [31:0] zext(input logic [OP_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[OP_WIDTH-1:0] = v;
        return r;
    endfunction

    state_t state;
    state_t state_next;

    logic [OP_WIDTH-1:0] operand [NUM_OPERANDS];
    logic [OP_WIDTH-1:0] result;
    logic [OP_WIDTH-1:0] acc;
    logic [OP_WIDTH-1:0] acc_next;
    logic [OP_WIDTH:0]   acc_sum;
    logic [IDX_W-1:0]    idx;
    logic                last_op;
    logic                sat_cfg;
    logic                sat_run;
    logic                busy;
    logic                done;
    logic                ovf;

    logic                aw_ready;
    logic                b_valid;
    logic [1:0]          b_resp;
    logic                ar_ready;
    logic                r_valid;
    logic [1:0]          r_resp;
    logic [31:0]         r_data;

    logic                wr_fire;
    logic [WORD_W-1:0]   wr_word;
    logic                wr_err;
    logic                ctrl_wr;
    logic                status_wr;
    logic                op_wr;
    logic [IDX_W-1:0]    op_wr_idx;
    logic [31:0]         op_merge;
    logic                start_req;
    logic                done_clr;

    logic                rd_fire;
    logic [WORD_W-1:0]   rd_word;
    logic [IDX_W-1:0]    op_rd_idx;
    logic [31:0]         rd_data;
    logic                rd_err;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write decode: classify the accepted write and build the byte-merged operand value.
    always_comb begin
        wr_fire   = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
        wr_word   = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        wr_err    = 1'b0;
        ctrl_wr   = 1'b0;
        status_wr = 1'b0;
        op_wr     = 1'b0;
        op_wr_idx = IDX_W'(wr_word - WORD_OP_FIRST);
        op_merge  = zext(operand[op_wr_idx]);
        for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) begin
                op_merge[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
        if (wr_fire) begin
            if (wr_word == WORD_CTRL) begin
                if (busy) begin
                    wr_err = 1'b1;
                end else begin
                    ctrl_wr = S_AXI_WSTRB[0];
                end
            end else if (wr_word == WORD_STATUS) begin
                status_wr = S_AXI_WSTRB[0];
            end else if (wr_word == WORD_RESULT) begin
                wr_err = 1'b1;
            end else if (wr_word >= WORD_OP_FIRST && wr_word <= WORD_OP_LAST) begin
                if (busy) begin
                    wr_err = 1'b1;
                end else begin
                    op_wr = 1'b1;
                end
            end else begin
                wr_err = 1'b1;
            end
        end
    end

    assign start_req = ctrl_wr && S_AXI_WDATA[0];
    assign done_clr  = status_wr && S_AXI_WDATA[1];

    // Read decode: select the register image for the addressed word.
    always_comb begin
        rd_fire   = ar_ready && S_AXI_ARVALID;
        rd_word   = S_AXI_ARADDR[ADDR_WIDTH-1:2];
        op_rd_idx = IDX_W'(rd_word - WORD_OP_FIRST);
        rd_data   = '0;
        rd_err    = 1'b0;
        if (rd_word == WORD_CTRL) begin
            rd_data[1] = sat_cfg;
        end else if (rd_word == WORD_STATUS) begin
            rd_data[2:0] = {ovf, done, busy};
        end else if (rd_word == WORD_RESULT) begin
            rd_data = zext(result);
        end else if (rd_word >= WORD_OP_FIRST && rd_word <= WORD_OP_LAST) begin
            rd_data = zext(operand[op_rd_idx]);
        end else begin
            rd_err = 1'b1;
        end
    end

    // Next-state logic and the adder; a carry under SAT pins acc at all-ones.
    always_comb begin
        state_next = state;
        acc_sum    = {1'b0, acc} + {1'b0, operand[idx]};
        acc_next   = acc_sum[OP_WIDTH-1:0];
        if (acc_sum[OP_WIDTH] && sat_run) begin
            acc_next = '1;
        end
        last_op = (idx == IDX_LAST);
        case (state)
            S_IDLE:  if (start_req) state_next = S_ACCUM;
            S_ACCUM: if (last_op) state_next = S_DONE;
            S_DONE:  state_next = start_req ? S_ACCUM : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign IRQ = (state == S_DONE);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Register file and engine datapath; posting DONE on the last add wins over a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_OPERANDS; k++) begin
                operand[k] <= '0;
            end
            result  <= '0;
            acc     <= '0;
            idx     <= '0;
            sat_cfg <= 1'b0;
            sat_run <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                sat_cfg <= S_AXI_WDATA[1];
            end
            if (op_wr) begin
                operand[op_wr_idx] <= op_merge[OP_WIDTH-1:0];
            end
            if (done_clr && state != S_DONE) begin
                done <= 1'b0;
            end
            if (start_req) begin
                acc     <= '0;
                idx     <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
                ovf     <= 1'b0;
                sat_run <= S_AXI_WDATA[1];
            end else if (state == S_ACCUM) begin
                acc <= acc_next;
                idx <= idx + 1'b1;
                if (acc_sum[OP_WIDTH]) begin
                    ovf <= 1'b1;
                end
                if (last_op) begin
                    result <= acc_next;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Write channel: one-cycle ready pulse, response held until BREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            aw_ready <= !aw_ready && !b_valid && S_AXI_AWVALID && S_AXI_WVALID;
            if (wr_fire) begin
                b_valid <= 1'b1;
                b_resp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (b_valid && S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle ready pulse, data captured and held until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_data   <= '0;
        end else begin
            ar_ready <= !ar_ready && !r_valid && S_AXI_ARVALID;
            if (rd_fire) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
                r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_valid && S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RRESP   = r_resp;
    assign S_AXI_RDATA   = r_data;

endmodule
